leaf_bft_endpoint: RTL and testbench

Network-side endpoint of one BFT leaf. It is the counterpart of a page's leaf interface: it drives packets into the page on dout_leaf_bft2interface and consumes packets the page emits on din_leaf_interface2bft. It applies back-pressure to the page via resend when its receive buffer is full. It also sequences ap_start toward the page after reset. A buffered stream side connects to the rest of the network or to the testbench.

---
 rtl/leaf_bft_endpoint_if.sv | 37 +++
 rtl/leaf_bft_endpoint.sv | 165 ++++++++++++++++
 tb/tb_leaf_bft_endpoint.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/leaf_bft_endpoint_if.sv
`default_nettype none
// ============================================================================
// Module      : leaf_bft_endpoint_if
// Description : Buffered stream side of the leaf BFT endpoint.
//               TX stream (s_tx_*) carries outbound words into the endpoint;
//               RX stream (m_rx_*) presents inbound words to the consumer.
// Ports       : s_tx_data[31:0], s_tx_port[4:0], s_tx_valid, s_tx_ready
//               m_rx_data[31:0], m_rx_port[4:0], m_rx_valid, m_rx_ready
//               modport slave  : endpoint view
//               modport master : network / testbench view
// Revision    : 1.0 - initial release
// ============================================================================
interface leaf_bft_endpoint_if;
  logic [31:0] s_tx_data;
  logic [4:0]  s_tx_port;
  logic        s_tx_valid;
  logic        s_tx_ready;
  logic [31:0] m_rx_data;
  logic [4:0]  m_rx_port;
  logic        m_rx_valid;
  logic        m_rx_ready;

  modport slave (
    input  s_tx_data, s_tx_port, s_tx_valid,
    output s_tx_ready,
    output m_rx_data, m_rx_port, m_rx_valid,
    input  m_rx_ready
  );

  modport master (
    output s_tx_data, s_tx_port, s_tx_valid,
    input  s_tx_ready,
    input  m_rx_data, m_rx_port, m_rx_valid,
    output m_rx_ready
  );
endinterface
`default_nettype wire

// File: rtl/leaf_bft_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : leaf_bft_endpoint
// Description : Network-side endpoint of one BFT leaf. Drives 49-bit packets
//               into the page from a TX FIFO, buffers packets from the page
//               in an RX FIFO (drop + resend pulse when full), flags
//               misrouted packets and sequences ap_start after reset.
// Ports       : clk_400, reset_400 (async, active high)
//               dout_leaf_bft2interface[48:0] packets toward the page
//               din_leaf_interface2bft[48:0]  packets from the page
//               resend, ap_start, err_misroute
//               strm : leaf_bft_endpoint_if.slave (TX / RX streams)
// Packet      : [48] valid, [47:43] leaf, [42:38] port, [37:32] rsvd,
//               [31:0] payload
// Revision    : 1.0 - initial release
// ============================================================================
module leaf_bft_endpoint #(
  parameter logic [4:0] LEAF_ADDR   = 5'd0,
  parameter int         RX_DEPTH    = 16,
  parameter int         TX_DEPTH    = 16,
  parameter int         START_DELAY = 16
) (
  input  wire logic        clk_400,
  input  wire logic        reset_400,
  output logic [48:0]      dout_leaf_bft2interface,
  input  wire logic [48:0] din_leaf_interface2bft,
  output logic             resend,
  output logic             ap_start,
  leaf_bft_endpoint_if.slave strm,
  output logic             err_misroute
);

  localparam int c_tx_aw = $clog2(TX_DEPTH);
  localparam int c_tx_cw = c_tx_aw + 1;
  localparam int c_rx_aw = $clog2(RX_DEPTH);
  localparam int c_rx_cw = c_rx_aw + 1;
  localparam int c_sw    = $clog2(START_DELAY + 1);

  localparam logic [c_tx_cw-1:0] c_tx_depth = c_tx_cw'(TX_DEPTH);
  localparam logic [c_rx_cw-1:0] c_rx_depth = c_rx_cw'(RX_DEPTH);
  localparam logic [c_sw-1:0]    c_start    = c_sw'(START_DELAY);
  localparam logic [c_sw-1:0]    c_start_m1 = c_sw'(START_DELAY - 1);

  // ---------------------------------------------------------------- TX path
  logic [36:0]        r_tx_mem [TX_DEPTH];
  logic [c_tx_aw-1:0] r_tx_wr, r_tx_rd;
  logic [c_tx_cw-1:0] r_tx_count, w_tx_count_next;
  logic               r_tx_ready;
  logic [48:0]        r_dout;
  logic               w_tx_push, w_tx_pop;

  assign w_tx_push = strm.s_tx_valid && r_tx_ready;
  // The output register drains the FIFO every cycle it holds anything.
  assign w_tx_pop  = (r_tx_count != '0);

  always_comb begin
    w_tx_count_next = r_tx_count;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_count_next = r_tx_count + c_tx_cw'(1);
      2'b01:   w_tx_count_next = r_tx_count - c_tx_cw'(1);
      default: w_tx_count_next = r_tx_count;
    endcase
  end

  always_ff @(posedge clk_400) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= {strm.s_tx_port, strm.s_tx_data};
  end

  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
      r_tx_ready <= 1'b0;
      r_dout     <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_tx_aw'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_tx_aw'(1);
      r_tx_count <= w_tx_count_next;
      // Registered so ready reads 0 during reset; tracks count < depth after.
      r_tx_ready <= (w_tx_count_next < c_tx_depth);
      r_dout     <= w_tx_pop ? {1'b1, LEAF_ADDR, r_tx_mem[r_tx_rd][36:32], 6'b0,
                                r_tx_mem[r_tx_rd][31:0]}
                             : 49'd0;
    end
  end

  assign dout_leaf_bft2interface = r_dout;
  assign strm.s_tx_ready         = r_tx_ready;

  // ---------------------------------------------------------------- RX path
  logic [36:0]        r_rx_mem [RX_DEPTH];
  logic [c_rx_aw-1:0] r_rx_wr, r_rx_rd;
  logic [c_rx_cw-1:0] r_rx_count, w_rx_count_next;
  logic               r_resend, r_err;
  logic               w_rx_hit, w_rx_miss, w_rx_full, w_rx_push, w_rx_pop;
  logic [5:0]         w_unused_rsvd;

  assign w_unused_rsvd = din_leaf_interface2bft[37:32];

  assign w_rx_hit  = din_leaf_interface2bft[48] &&
                     (din_leaf_interface2bft[47:43] == LEAF_ADDR);
  assign w_rx_miss = din_leaf_interface2bft[48] &&
                     (din_leaf_interface2bft[47:43] != LEAF_ADDR);
  // Fullness is taken before any same-cycle pop: a full FIFO drops even
  // when the consumer frees a slot on this edge.
  assign w_rx_full = (r_rx_count == c_rx_depth);
  assign w_rx_push = w_rx_hit && !w_rx_full;
  assign w_rx_pop  = (r_rx_count != '0) && strm.m_rx_ready;

  always_comb begin
    w_rx_count_next = r_rx_count;
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_count_next = r_rx_count + c_rx_cw'(1);
      2'b01:   w_rx_count_next = r_rx_count - c_rx_cw'(1);
      default: w_rx_count_next = r_rx_count;
    endcase
  end

  always_ff @(posedge clk_400) begin
    if (w_rx_push)
      r_rx_mem[r_rx_wr] <= {din_leaf_interface2bft[42:38], din_leaf_interface2bft[31:0]};
  end

  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
      r_resend   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_rx_aw'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_rx_aw'(1);
      r_rx_count <= w_rx_count_next;
      r_resend   <= w_rx_hit && w_rx_full;
      if (w_rx_miss) r_err <= 1'b1;
    end
  end

  assign resend          = r_resend;
  assign err_misroute    = r_err;
  assign strm.m_rx_valid = (r_rx_count != '0);
  assign strm.m_rx_data  = r_rx_mem[r_rx_rd][31:0];
  assign strm.m_rx_port  = r_rx_mem[r_rx_rd][36:32];

  // --------------------------------------------------------------- ap_start
  logic [c_sw-1:0] r_start_cnt;
  logic            r_ap_start;

  always_ff @(posedge clk_400 or posedge reset_400) begin
    if (reset_400) begin
      r_start_cnt <= '0;
      r_ap_start  <= 1'b0;
    end else begin
      if (r_start_cnt != c_start) r_start_cnt <= r_start_cnt + c_sw'(1);
      // Rises together with the counter reaching START_DELAY.
      if (r_start_cnt == c_start_m1) r_ap_start <= 1'b1;
    end
  end

  assign ap_start = r_ap_start;

endmodule
`default_nettype wire

// File: tb/tb_leaf_bft_endpoint.sv
`default_nettype none
// ============================================================================
// Module      : tb_leaf_bft_endpoint
// Description : Directed self-checking bench for leaf_bft_endpoint
//               (LEAF_ADDR=5, depths 16, START_DELAY=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_bft_endpoint;
  localparam logic [4:0] c_leaf = 5'd5;

  logic        clk_400 = 1'b0;
  logic        reset_400;
  logic [48:0] dout;
  logic [48:0] din;
  logic        resend, ap_start, err_misroute;
  int          n_checks = 0;
  int          n_fail   = 0;

  leaf_bft_endpoint_if bus ();

  leaf_bft_endpoint #(
    .LEAF_ADDR(c_leaf), .RX_DEPTH(16), .TX_DEPTH(16), .START_DELAY(16)
  ) dut (
    .clk_400                 (clk_400),
    .reset_400               (reset_400),
    .dout_leaf_bft2interface (dout),
    .din_leaf_interface2bft  (din),
    .resend                  (resend),
    .ap_start                (ap_start),
    .strm                    (bus),
    .err_misroute            (err_misroute)
  );

  always #5 clk_400 = ~clk_400;

  function automatic logic [48:0] rx_pkt(input logic [4:0] leaf, input int j);
    return {1'b1, leaf, 5'(j), 6'h3F, 32'hC0DE0000 + 32'(j)};
  endfunction

  task automatic test_reset;
    reset_400 = 1'b1;
    din = '0;
    bus.s_tx_valid = 1'b0; bus.s_tx_data = '0; bus.s_tx_port = '0;
    bus.m_rx_ready = 1'b0;
    repeat (3) @(negedge clk_400);
    n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
    n_checks++; if (resend !== 1'b0) begin n_fail++; $display("FAIL reset_resend got=%b exp=0", resend); end
    n_checks++; if (ap_start !== 1'b0) begin n_fail++; $display("FAIL reset_ap_start got=%b exp=0", ap_start); end
    n_checks++; if (bus.s_tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=0", bus.s_tx_ready); end
    n_checks++; if (bus.m_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", bus.m_rx_valid); end
    n_checks++; if (err_misroute !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_misroute); end
  endtask

  task automatic test_ap_start;
    reset_400 = 1'b0;
    for (int k = 1; k <= 116; k++) begin
      @(negedge clk_400);
      n_checks++;
      if (ap_start !== (k >= 16)) begin
        n_fail++; $display("FAIL ap_start cycle=%0d got=%b exp=%b", k, ap_start, (k >= 16));
      end
    end
    n_checks++; if (bus.s_tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_idle got=%b exp=1", bus.s_tx_ready); end
  endtask

  task automatic test_tx_single;
    bus.s_tx_valid = 1'b1; bus.s_tx_data = 32'hDEADBEEF; bus.s_tx_port = 5'd3;
    @(negedge clk_400);
    bus.s_tx_valid = 1'b0;
    n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL tx_single_pre got=%h exp=0", dout); end
    @(negedge clk_400);
    n_checks++;
    if (dout !== {1'b1, 5'd5, 5'd3, 6'd0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL tx_single got=%h exp=%h", dout, {1'b1, 5'd5, 5'd3, 6'd0, 32'hDEADBEEF});
    end
    @(negedge clk_400);
    n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL tx_single_post got=%h exp=0", dout); end
  endtask

  task automatic test_tx_stream;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (bus.s_tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_stream_ready i=%0d got=%b exp=1", i, bus.s_tx_ready); end
      bus.s_tx_valid = 1'b1; bus.s_tx_data = 32'hA5000000 + 32'(i); bus.s_tx_port = 5'(i);
      @(negedge clk_400);
      if (i > 0) begin
        n_checks++;
        if (dout !== {1'b1, c_leaf, 5'(i - 1), 6'd0, 32'hA5000000 + 32'(i - 1)}) begin
          n_fail++; $display("FAIL tx_stream i=%0d got=%h", i - 1, dout);
        end
      end
    end
    bus.s_tx_valid = 1'b0;
    @(negedge clk_400);
    n_checks++;
    if (dout !== {1'b1, c_leaf, 5'd19, 6'd0, 32'hA5000013}) begin
      n_fail++; $display("FAIL tx_stream_last got=%h", dout);
    end
    @(negedge clk_400);
    n_checks++; if (dout !== 49'd0) begin n_fail++; $display("FAIL tx_stream_idle got=%h exp=0", dout); end
  endtask

  // Fill RX, overflow twice back to back, then drain while a packet hits the
  // still-full FIFO on the first pop edge.
  task automatic test_back_to_back;
    bus.m_rx_ready = 1'b0;
    for (int j = 0; j < 18; j++) begin
      din = rx_pkt(c_leaf, j);
      @(negedge clk_400);
      n_checks++;
      if (resend !== (j >= 16)) begin
        n_fail++; $display("FAIL rx_fill_resend j=%0d got=%b exp=%b", j, resend, (j >= 16));
      end
    end
    din = '0;
    @(negedge clk_400);
    n_checks++; if (resend !== 1'b0) begin n_fail++; $display("FAIL rx_resend_end got=%b exp=0", resend); end
    bus.m_rx_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (bus.m_rx_valid !== 1'b1 || bus.m_rx_data !== 32'hC0DE0000 + 32'(j) || bus.m_rx_port !== 5'(j)) begin
        n_fail++; $display("FAIL rx_drain j=%0d got v=%b d=%h p=%h exp d=%h p=%h", j,
                           bus.m_rx_valid, bus.m_rx_data, bus.m_rx_port, 32'hC0DE0000 + 32'(j), 5'(j));
      end
      din = (j == 0) ? rx_pkt(c_leaf, 99) : 49'd0;
      @(negedge clk_400);
      if (j == 0) begin
        n_checks++; if (resend !== 1'b1) begin n_fail++; $display("FAIL rx_full_pop_drop got=%b exp=1", resend); end
      end
    end
    n_checks++; if (bus.m_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_empty got=%b exp=0", bus.m_rx_valid); end
    bus.m_rx_ready = 1'b0;
  endtask

  task automatic test_misroute;
    n_checks++; if (err_misroute !== 1'b0) begin n_fail++; $display("FAIL err_pre got=%b exp=0", err_misroute); end
    din = rx_pkt(5'd7, 1);
    @(negedge clk_400);
    din = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (err_misroute !== 1'b1 || resend !== 1'b0 || bus.m_rx_valid !== 1'b0) begin
        n_fail++; $display("FAIL misroute k=%0d got err=%b resend=%b valid=%b exp 1 0 0",
                           k, err_misroute, resend, bus.m_rx_valid);
      end
      @(negedge clk_400);
    end
  endtask

  task automatic test_reset_mid;
    for (int j = 0; j < 17; j++) begin
      din = rx_pkt(c_leaf, j);
      bus.s_tx_valid = 1'b1; bus.s_tx_data = 32'h5A000000 + 32'(j); bus.s_tx_port = 5'd2;
      @(negedge clk_400);
    end
    n_checks++; if (resend !== 1'b1) begin n_fail++; $display("FAIL mid_resend_pending got=%b exp=1", resend); end
    n_checks++;
    if (dout !== {1'b1, c_leaf, 5'd2, 6'd0, 32'h5A00000F}) begin
      n_fail++; $display("FAIL mid_dout_active got=%h", dout);
    end
    reset_400 = 1'b1;
    #1;
    n_checks++;
    if (dout !== 49'd0 || resend !== 1'b0 || ap_start !== 1'b0 || bus.s_tx_ready !== 1'b0 ||
        bus.m_rx_valid !== 1'b0 || err_misroute !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_reset got dout=%h rs=%b ap=%b rdy=%b v=%b err=%b exp all 0",
                         dout, resend, ap_start, bus.s_tx_ready, bus.m_rx_valid, err_misroute);
    end
    din = '0; bus.s_tx_valid = 1'b0;
    repeat (2) @(negedge clk_400);
    reset_400 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_400);
      n_checks++;
      if (dout !== 49'd0 || bus.m_rx_valid !== 1'b0 || resend !== 1'b0 || ap_start !== 1'b0) begin
        n_fail++; $display("FAIL mid_after_release k=%0d got dout=%h v=%b rs=%b ap=%b exp 0",
                           k, dout, bus.m_rx_valid, resend, ap_start);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ap_start();
    test_tx_single();
    test_tx_stream();
    test_back_to_back();
    test_misroute();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
